fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage directly upstream of the main opcode decoder. Holds the PC,
//   issues req/ack reads to instruction memory, buffers one returned word in an IF/ID
//   register plus a 1-entry skid, and presents instr/op (op = instr[31:26]) to decode.
//   Applies branch/jump redirects computed from the instruction currently in IF/ID.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of the first fetch after reset; must be word-aligned
// PORTS
//   clk              in   1   single clock, all state on rising edge
//   rst_n            in   1   asynchronous, active-low reset
//   imem_req         out  1   read request to instruction memory
//   imem_addr        out  32  word-aligned read address (bits [1:0] always 0)
//   imem_ack         in   1   read data valid this cycle for the outstanding request
//   imem_rdata       in   32  instruction word, valid with imem_ack
//   stall            in   1   decode cannot consume the IF/ID word this cycle
//   branch_taken     in   1   IF/ID instr is a taken branch (meaningful only when consumed)
//   branch_imm       in   16  branch offset field of IF/ID instr
//   jump_taken       in   1   IF/ID instr is a jump (meaningful only when consumed)
//   jump_index       in   26  jump index field of IF/ID instr
//   instr_valid      out  1   IF/ID holds a valid instruction
//   instr            out  32  IF/ID instruction word
//   op               out  6   instr[31:26], feeds main decoder
//   instr_pc         out  32  address of instr
//   pc_plus4         out  32  instr_pc + 4
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, op=0,
//     instr_pc=0, pc_plus4=0, skid empty, squash=0, state=S_BOOT.
//   consume = instr_valid & ~stall. Redirect inputs ignored unless consume=1.
//   FSM:
//     S_BOOT: imem_req=0; next cycle -> S_REQ (first req 1 cycle after rst_n rises).
//     S_REQ : imem_req=1; imem_addr=pc held stable until ack. On ack:
//             squash=1 -> drop data, clear squash, stay S_REQ (re-request at new pc);
//             else slot free (~instr_valid | consume) -> load IF/ID, pc+=4, stay S_REQ;
//             else -> write skid, pc+=4, go S_SKID.
//     S_SKID: imem_req=0; on consume move skid -> IF/ID (instr_valid stays 1), -> S_REQ.
//   Load into IF/ID sets instr, op, instr_pc (=address fetched), pc_plus4, instr_valid=1.
//   consume with no same-cycle load -> instr_valid=0 next cycle.
//   Redirect (consume & (jump_taken|branch_taken)); jump has priority if both:
//     jump target  = {pc_plus4[31:28], jump_index, 2'b00}
//     branch target= pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}, mod 2^32
//     Effects next cycle: pc=target; instr_valid=0 (no load that cycle); skid emptied;
//     state -> S_REQ. If a request is outstanding without ack this cycle, squash=1.
//     If ack arrives in the redirect cycle, its data is dropped (no squash needed).
//   Ack is never asserted without imem_req; ack when imem_req=0 is ignored.
//   Addition wraps: pc 32'hFFFF_FFFC + 4 -> 0.
//   Reset mid-request: all state returns to reset values; any later ack ignored
//     until S_REQ is re-entered.
//   Throughput: 1 instr/cycle with single-cycle ack and stall=0.
// TESTING
//   1. Reset release, ack every cycle, stall=0 -> imem_addr 0,4,8...; instr_valid from
//      cycle after first ack; instr_pc tracks addresses; op = rdata[31:26].
//   2. Ack delayed 3 cycles on addr 8 -> imem_req, imem_addr=8 held all 3 cycles;
//      instr_valid=0 during gap after consuming addr 4.
//   3. stall held 4 cycles while ack returns -> skid filled, imem_req=0, IF/ID unchanged;
//      stall drops -> skid word appears next cycle, requests resume at next pc.
//   4. Consumed branch at instr_pc=0x10, branch_imm=16'hFFFC -> next imem_addr=0x04;
//      in-flight sequential fetch squashed, never reaches instr_valid.
//   5. Consumed jump at instr_pc=0xF000_0020, jump_index=26'h40 -> next addr
//      0xF000_0100; branch_taken also 1 -> jump wins.
//   6. rst_n asserted while req outstanding, ack after reset -> ack ignored,
//      outputs at reset values, first fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack reads, IF/ID register plus one-entry skid.
// Branch/jump redirects come from the instruction held in IF/ID when decode consumes it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump_taken,
    input  logic [25:0] jump_index,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_SKID
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_squash;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ipc;
    logic [31:0] r_pc4;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic        w_squash_n;
    logic        w_valid_n;
    logic        w_load;
    logic [31:0] w_ld_instr;
    logic [31:0] w_ld_pc;
    logic        w_skid_wr;
    logic        w_consume;
    logic        w_redirect;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_br_off;
    logic [31:0] w_target;

    assign w_req      = (r_state == S_REQ);
    assign w_ack      = imem_ack & w_req;
    assign w_consume  = r_valid & ~stall;
    assign w_redirect = w_consume & (jump_taken | branch_taken);
    assign w_br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_target   = jump_taken ? {r_pc4[31:28], jump_index, 2'b00}
                                   : r_pc4 + w_br_off;

    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_squash_n = r_squash;
        w_valid_n  = r_valid & ~w_consume;
        w_load     = 1'b0;
        w_ld_instr = r_instr;
        w_ld_pc    = r_ipc;
        w_skid_wr  = 1'b0;
        if (w_redirect) begin
            // An ack landing in this cycle is simply dropped; only a
            // still-pending request needs to be squashed later.
            w_pc_n     = w_target;
            w_state_n  = S_REQ;
            w_squash_n = w_req & ~imem_ack;
            w_valid_n  = 1'b0;
        end else begin
            unique case (r_state)
                S_BOOT: w_state_n = S_REQ;
                S_REQ: begin
                    if (w_ack) begin
                        if (r_squash) begin
                            w_squash_n = 1'b0;
                        end else if (~r_valid | w_consume) begin
                            w_load     = 1'b1;
                            w_ld_instr = imem_rdata;
                            w_ld_pc    = r_pc;
                            w_pc_n     = r_pc + 32'd4;
                        end else begin
                            w_skid_wr  = 1'b1;
                            w_pc_n     = r_pc + 32'd4;
                            w_state_n  = S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (w_consume) begin
                        w_load     = 1'b1;
                        w_ld_instr = r_skid_instr;
                        w_ld_pc    = r_skid_pc;
                        w_state_n  = S_REQ;
                    end
                end
                default: w_state_n = S_BOOT;
            endcase
            if (w_load) begin
                w_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_ipc        <= 32'd0;
            r_pc4        <= 32'd0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
        end else begin
            r_state  <= w_state_n;
            r_pc     <= w_pc_n;
            r_squash <= w_squash_n;
            r_valid  <= w_valid_n;
            if (w_load) begin
                r_instr <= w_ld_instr;
                r_ipc   <= w_ld_pc;
                r_pc4   <= w_ld_pc + 32'd4;
            end
            if (w_skid_wr) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign instr_pc    = r_ipc;
    assign pc_plus4    = r_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Random-latency memory, random stall/redirects; a program-order PC model
// predicts every consumed instruction, checked by a separate monitor.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump_taken = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump_taken(jump_taken), .jump_index(jump_index),
        .instr_valid(instr_valid), .instr(instr), .op(op),
        .instr_pc(instr_pc), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        j;
        logic        b;
        logic [15:0] imm;
        logic [25:0] idx;
    } force_t;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    bit run = 1'b0;
    bit thr_chk = 1'b0;
    bit force_ack = 1'b0;
    int ack_pct = 100;
    int stall_pct = 0;
    int br_pct = 0;
    logic [31:0] model_cur = RST_PC;
    logic [31:0] exp_q[$];
    force_t      force_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Architectural successor of the instruction at address cur.
    function automatic logic [31:0] next_pc(input logic [31:0] cur,
                                            input logic j, input logic b,
                                            input logic [15:0] imm,
                                            input logic [25:0] idx);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = cur + 32'd4;
        off = {{16{imm[15]}}, imm};
        if (j) return {p4[31:28], idx, 2'b00};
        if (b) return p4 + (off << 2);
        return p4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: memory responder, stall and redirect stimulus, model update.
    initial begin
        force_t f;
        logic [31:0] nxt;
        forever begin
            @(negedge clk);
            if (run) begin
                imem_ack = imem_req && ($urandom_range(0, 99) < ack_pct);
                imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
                stall = ($urandom_range(0, 99) < stall_pct);
                jump_taken = ($urandom_range(0, 99) < br_pct);
                branch_taken = ($urandom_range(0, 99) < br_pct);
                branch_imm = 16'($urandom);
                jump_index = 26'($urandom);
                if (instr_valid && !stall) begin
                    if (force_q.size() > 0) begin
                        f = force_q.pop_front();
                        jump_taken = f.j;
                        branch_taken = f.b;
                        branch_imm = f.imm;
                        jump_index = f.idx;
                    end
                    nxt = next_pc(model_cur, jump_taken, branch_taken,
                                  branch_imm, jump_index);
                    exp_q.push_back(nxt);
                    model_cur = nxt;
                end
            end else begin
                imem_ack = force_ack;
                imem_rdata = $urandom;
                stall = 1'b1;
                jump_taken = 1'b0;
                branch_taken = 1'b0;
            end
        end
    end

    // Monitor: pops the expected PC whenever decode consumes IF/ID.
    initial begin
        logic [31:0] e;
        logic [31:0] prev_addr;
        bit prev_pending;
        int idle;
        prev_pending = 1'b0;
        prev_addr = 32'd0;
        idle = 0;
        forever begin
            @(negedge clk);
            #1;
            if (run) begin
                if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                if (prev_pending && imem_req)
                    chk("addr_hold", imem_addr, prev_addr);
                if (thr_chk) chk("throughput", 32'(instr_valid), 32'd1);
                if (instr_valid && !stall) begin
                    idle = 0;
                    delivered++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got pc %h expected none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_pc", instr_pc, e);
                        chk("instr", instr, memf(e));
                        chk("op", 32'(op), 32'(memf(e) >> 26));
                        chk("pc_plus4", pc_plus4, e + 32'd4);
                    end
                end else begin
                    idle++;
                    if (idle > 300) begin
                        checks++;
                        errors++;
                        $display("FAIL watchdog: got 0 consumes expected >0 in 300 cycles");
                        idle = 0;
                    end
                end
                prev_pending = imem_req && !imem_ack &&
                    !(instr_valid && !stall && (jump_taken || branch_taken));
                prev_addr = imem_addr;
            end else begin
                prev_pending = 1'b0;
                idle = 0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_op"}, 32'(op), 32'd0);
        chk({tag, "_ipc"}, instr_pc, 32'd0);
        chk({tag, "_pc4"}, pc_plus4, 32'd0);
    endtask

    initial begin
        exp_q.push_back(RST_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(imem_req), 32'd0);

        // Single-cycle ack, no stall: one instruction per cycle.
        @(posedge clk);
        ack_pct = 100; stall_pct = 0; br_pct = 0;
        run = 1'b1;
        @(negedge clk);
        #2;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        @(posedge clk);
        thr_chk = 1'b1;
        repeat (40) @(posedge clk);
        thr_chk = 1'b0;

        // Directed redirects: branch back, wrap, jump priority, pc wrap.
        ack_pct = 60; stall_pct = 20; br_pct = 0;
        force_q.push_back('{j: 1'b1, b: 1'b0, imm: 16'h0000, idx: 26'h4});
        force_q.push_back('{j: 1'b0, b: 1'b1, imm: 16'hFFFC, idx: 26'h0});
        force_q.push_back('{j: 1'b0, b: 1'b1, imm: 16'hFFFC, idx: 26'h0});
        force_q.push_back('{j: 1'b1, b: 1'b1, imm: 16'h0100, idx: 26'h8});
        force_q.push_back('{j: 1'b1, b: 1'b1, imm: 16'h0004, idx: 26'h40});
        force_q.push_back('{j: 1'b1, b: 1'b0, imm: 16'h0000, idx: 26'h3FF_FFFF});
        force_q.push_back('{j: 1'b0, b: 1'b0, imm: 16'h0000, idx: 26'h0});
        repeat (150) @(posedge clk);
        chk("force_drained", 32'(force_q.size()), 32'd0);

        ack_pct = 50; stall_pct = 30; br_pct = 20;
        repeat (600) @(posedge clk);

        // Long stalls with fast memory keep the skid busy.
        ack_pct = 100; stall_pct = 75; br_pct = 10;
        repeat (300) @(posedge clk);

        // Reset while a request is outstanding; stray ack during boot.
        ack_pct = 0; stall_pct = 0; br_pct = 0;
        repeat (6) @(posedge clk);
        run = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        model_cur = RST_PC;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        #2;
        chk("rb_valid", 32'(instr_valid), 32'd0);
        chk("rb_req", 32'(imem_req), 32'd1);
        chk("rb_addr", imem_addr, RST_PC);
        @(posedge clk);
        ack_pct = 70; stall_pct = 20; br_pct = 15;
        run = 1'b1;
        repeat (200) @(posedge clk);
        run = 1'b0;
        @(negedge clk);
        #3;
        chk("sb_level", 32'(exp_q.size()), 32'd1);
        chk("delivered_min", 32'(delivered >= 300), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
